// File: rtl/hazard_sweep_checker_pkg.sv
// Shared types and helpers for the hazard sweep checker: sweep FSM encoding,
// number of swept codes and the 4-bit Gray-code mapping.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int N_CODES = 16;

    function automatic logic [3:0] gray4(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/hazard_sweep_checker_if.sv
// Bundle between the sweep checker and the circuit pair under test: stimulus
// out, the two circuit outputs back in, and the captured results.
interface hazard_sweep_checker_if;
    import hazard_pkg::*;

    logic        f_pre;
    logic        f_post;
    logic [3:0]  abcd;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  mismatch_cnt;
    // first_fail is meaningful only while first_fail_vld is high; there is no
    // backpressure, every field is a level that holds until the next sweep.
    logic [3:0]  first_fail;
    logic        first_fail_vld;
    logic [15:0] truth_pre;
    logic [15:0] truth_post;
    state_e      state;

    modport master (
        input  f_pre, f_post,
        output abcd, busy, done, pass, mismatch_cnt, first_fail,
               first_fail_vld, truth_pre, truth_post, state
    );

    modport slave (
        output f_pre, f_post,
        input  abcd, busy, done, pass, mismatch_cnt, first_fail,
               first_fail_vld, truth_pre, truth_post, state
    );

endinterface

// File: rtl/hazard_sweep_checker_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    // Counting only while the synchronised input disagrees with the level
    // means any toggle of the input restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_q <= sync2_q;
                pulse_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/hazard_sweep_checker.sv
// Sweeps all 16 {d,c,b,a} codes in Gray order, samples f_pre/f_post at the end
// of each step and records truth tables, mismatch count and first failing code.
module hazard_sweep_checker
    import hazard_pkg::*;
#(
    parameter int DEB_CYCLES  = 2_000_000,
    parameter int STEP_CYCLES = 100_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    hazard_sweep_checker_if.master bus
);

    localparam int SW = $clog2(STEP_CYCLES);

    logic          start_pulse;
    logic          deb_level;

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [SW-1:0] step_q, step_d;
    logic [3:0]    abcd_q, abcd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [4:0]    mm_q, mm_d;
    logic [3:0]    ff_q, ff_d;
    logic          ffv_q, ffv_d;
    logic [15:0]   tp_q, tp_d;
    logic [15:0]   tq_q, tq_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (start_btn),
        .level_o (deb_level),
        .pulse_o (start_pulse)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        step_d  = step_q;
        abcd_d  = abcd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        mm_d    = mm_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        tp_d    = tp_q;
        tq_d    = tq_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_pulse) begin
                    state_d = RUN;
                    idx_d   = '0;
                    step_d  = '0;
                    abcd_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    mm_d    = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    tp_d    = '0;
                    tq_d    = '0;
                end
            end
            RUN: begin
                if (step_q == SW'(STEP_CYCLES - 1)) begin
                    tp_d[abcd_q] = bus.f_pre;
                    tq_d[abcd_q] = bus.f_post;
                    if (bus.f_pre != bus.f_post) begin
                        mm_d = mm_q + 5'd1;
                        if (!ffv_q) begin
                            ff_d  = abcd_q;
                            ffv_d = 1'b1;
                        end
                    end
                    step_d = '0;
                    idx_d  = idx_q + 4'd1;
                    // The last code stays on the pins after the sweep ends.
                    if (idx_q == 4'(N_CODES - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (mm_d == 5'd0);
                    end else begin
                        abcd_d = gray4(idx_q + 4'd1);
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            step_q  <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mm_q    <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            tp_q    <= '0;
            tq_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            tp_q    <= tp_d;
            tq_q    <= tq_d;
        end
    end

    assign bus.abcd           = abcd_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.mismatch_cnt   = mm_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ffv_q;
    assign bus.truth_pre      = tp_q;
    assign bus.truth_post     = tq_q;
    assign bus.state          = state_q;

    logic unused_level;
    assign unused_level = deb_level;

endmodule

// File: tb/tb_hazard_sweep_checker.sv
// Directed bench for hazard_sweep_checker: drives a behavioural pre/post
// circuit pair from abcd and checks each sweep against an expected-code queue.
module tb_hazard_sweep_checker;
  import hazard_pkg::*;

  localparam int DEB  = 4;
  localparam int STEP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_btn = 1'b0;
  logic fault_en = 1'b0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int busy_rises = 0;
  logic busy_prev = 1'b0;

  logic [3:0] exp_q[$];
  logic [3:0] gray_seq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  hazard_sweep_checker_if bus ();

  hazard_sweep_checker #(.DEB_CYCLES(DEB), .STEP_CYCLES(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .bus       (bus)
  );

  // ---------------- clock / circuit pair model ----------------
  always #5 clk = ~clk;

  function automatic logic model_f(input logic [3:0] v);
    logic a, b, c, d;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    return (a & c) | (b & ~c & d) | (a & ~b & ~c);
  endfunction

  function automatic logic fault_hit(input logic [3:0] v);
    return (v == 4'h6) || (v == 4'hA);
  endfunction

  assign bus.f_pre  = model_f(bus.abcd);
  assign bus.f_post = model_f(bus.abcd) ^ (fault_en & fault_hit(bus.abcd));

  always @(posedge clk) begin
    if (bus.busy && !busy_prev) busy_rises++;
    busy_prev <= bus.busy;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abcd"},  32'(bus.abcd), 32'(0));
    check({tag, "_busy"},  32'(bus.busy), 32'(0));
    check({tag, "_done"},  32'(bus.done), 32'(0));
    check({tag, "_pass"},  32'(bus.pass), 32'(0));
    check({tag, "_mm"},    32'(bus.mismatch_cnt), 32'(0));
    check({tag, "_ff"},    32'(bus.first_fail), 32'(0));
    check({tag, "_ffv"},   32'(bus.first_fail_vld), 32'(0));
    check({tag, "_tpre"},  32'(bus.truth_pre), 32'(0));
    check({tag, "_tpost"}, 32'(bus.truth_post), 32'(0));
    check({tag, "_state"}, 32'(bus.state), 32'(IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic press_clean();
    start_btn = 1'b1;
    repeat (10) @(negedge clk);
    start_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_bounce();
    for (int i = 0; i < 10; i++) begin
      start_btn = ~start_btn;
      repeat (2) @(negedge clk);
    end
    press_clean();
  endtask

  // Scoreboard for one sweep: expected codes and results built from the model
  // and the fixed Gray sequence, then compared cycle by cycle from RUN entry.
  task automatic check_sweep(input string tag);
    logic [15:0] tp, tq;
    logic [3:0]  ff, cur;
    logic        ffv;
    int          mm, waited;
    tp = '0; tq = '0; ff = '0; ffv = 1'b0; mm = 0; waited = 0; cur = '0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(gray_seq[i]);
      tp[gray_seq[i]] = model_f(gray_seq[i]);
      tq[gray_seq[i]] = model_f(gray_seq[i]) ^ (fault_en & fault_hit(gray_seq[i]));
      if (tp[gray_seq[i]] != tq[gray_seq[i]]) begin
        mm++;
        if (!ffv) begin
          ff = gray_seq[i];
          ffv = 1'b1;
        end
      end
    end
    while (!bus.busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_entry_busy"}, 32'(bus.busy), 32'(1));
    if (bus.busy !== 1'b1) return;
    check({tag, "_entry_done"},  32'(bus.done), 32'(0));
    check({tag, "_entry_state"}, 32'(bus.state), 32'(RUN));
    check({tag, "_clr_mm"},      32'(bus.mismatch_cnt), 32'(0));
    check({tag, "_clr_ffv"},     32'(bus.first_fail_vld), 32'(0));
    check({tag, "_clr_tpre"},    32'(bus.truth_pre), 32'(0));
    check({tag, "_clr_tpost"},   32'(bus.truth_post), 32'(0));
    for (int k = 0; k < 16 * STEP; k++) begin
      if (k % STEP == 0) cur = exp_q.pop_front();
      check($sformatf("%s_abcd_c%0d", tag, k), 32'(bus.abcd), 32'(cur));
      if (k == 16 * STEP - 1) begin
        check({tag, "_last_busy"}, 32'(bus.busy), 32'(1));
        check({tag, "_last_done"}, 32'(bus.done), 32'(0));
      end
      @(negedge clk);
    end
    check({tag, "_done"},   32'(bus.done), 32'(1));
    check({tag, "_busy"},   32'(bus.busy), 32'(0));
    check({tag, "_state"},  32'(bus.state), 32'(DONE));
    check({tag, "_pass"},   32'(bus.pass), 32'(mm == 0));
    check({tag, "_mm"},     32'(bus.mismatch_cnt), 32'(mm));
    check({tag, "_ffv"},    32'(bus.first_fail_vld), 32'(ffv));
    check({tag, "_ff"},     32'(bus.first_fail), 32'(ff));
    check({tag, "_tpre"},   32'(bus.truth_pre), 32'(tp));
    check({tag, "_tpost"},  32'(bus.truth_post), 32'(tq));
    check({tag, "_hold"},   32'(bus.abcd), 32'(4'h8));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int waited;

    // Reset and idle quiet period
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    begin
      logic moved;
      moved = 1'b0;
      repeat (50) begin
        @(negedge clk);
        if (bus.abcd !== 4'h0 || bus.busy !== 1'b0) moved = 1'b1;
      end
      check("idle_quiet", 32'(moved), 32'(0));
    end

    // Bouncy press then a clean sweep
    fork
      press_bounce();
      check_sweep("clean1");
    join
    check("clean1_tpre_const",  32'(bus.truth_pre), 32'(16'hAEA2));
    check("clean1_tpost_const", 32'(bus.truth_post), 32'(16'hAEA2));
    check("bounce_one_run", 32'(busy_rises), 32'(1));

    // Faulty post circuit, restart from DONE, extra press mid-run
    fault_en = 1'b1;
    fork
      begin
        press_clean();
        repeat (4) @(negedge clk);
        press_clean();
      end
      check_sweep("fault");
    join
    check("fault_mm_const", 32'(bus.mismatch_cnt), 32'(2));
    check("fault_ff_const", 32'(bus.first_fail), 32'(4'h6));
    check("midrun_ignored", 32'(busy_rises), 32'(2));

    // Restart from DONE with mismatches recorded: results must clear
    fault_en = 1'b0;
    fork
      press_clean();
      check_sweep("clean2");
    join

    // Reset in the middle of a sweep
    fork
      press_clean();
      begin
        waited = 0;
        while (!(bus.busy && bus.abcd == 4'h4) && waited < 200) begin
          @(negedge clk);
          waited++;
        end
      end
    join
    check("abort_reached_4", 32'(bus.abcd), 32'(4'h4));
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_abort");
    fork
      press_clean();
      check_sweep("clean3");
    join
    check("total_runs", 32'(busy_rises), 32'(5));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
